// File: rtl/fp_nn_pkg.sv
// Shared fp32 types and constants for the arbitrated fp adder.
package fp_nn_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t       FP32_QNAN = 32'h7FC0_0000;
    localparam fp32_t       FP32_PINF = 32'h7F80_0000;
    localparam int unsigned PERF_W    = 32;

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE754 single-precision adder, round-to-nearest-even,
// subnormal inputs and results flushed to signed zero.
module fp_adder
    import fp_nn_pkg::*;
(
    input  fp32_t dataa,
    input  fp32_t datab,
    output fp32_t result
);

    fp32_t       big, sml;
    logic [26:0] big_m, sml_m;
    logic [7:0]  shamt;
    logic        sticky;
    logic [27:0] sum;
    logic [26:0] norm;
    logic [4:0]  lz;
    logic        found, uflow, rnd_up;
    logic [9:0]  exp_n;
    logic [24:0] rnd;
    logic        nan_a, nan_b, inf_a, inf_b;

    always_comb begin
        nan_a = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
        nan_b = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0);
        inf_a = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
        inf_b = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'd0);

        if (dataa[30:0] >= datab[30:0]) begin
            big = dataa;
            sml = datab;
        end else begin
            big = datab;
            sml = dataa;
        end

        // Three low bits carry guard, round and sticky through alignment.
        big_m = (big[30:23] == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
        sml_m = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
        shamt = big[30:23] - sml[30:23];
        if (shamt > 8'd26) begin
            sticky = |sml_m;
            sml_m  = 27'd0;
        end else begin
            sticky = |(sml_m & ((27'd1 << shamt) - 27'd1));
            sml_m  = sml_m >> shamt;
        end
        sml_m[0] = sml_m[0] | sticky;

        if (big[31] == sml[31]) begin
            sum = {1'b0, big_m} + {1'b0, sml_m};
        end else begin
            sum = {1'b0, big_m} - {1'b0, sml_m};
        end

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                found = 1'b1;
                lz    = 5'(26 - i);
            end
        end

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, big[30:23]} + 10'd1;
            uflow = 1'b0;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = {2'b00, big[30:23]} - {5'd0, lz};
            uflow = ({3'd0, lz} >= big[30:23]);
        end

        rnd_up = norm[2] && (norm[3] || norm[1] || norm[0]);
        rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (rnd[24]) begin
            exp_n = exp_n + 10'd1;
        end

        if (nan_a || nan_b || (inf_a && inf_b && (dataa[31] != datab[31]))) begin
            result = FP32_QNAN;
        end else if (inf_a) begin
            result = dataa;
        end else if (inf_b) begin
            result = datab;
        end else if (sum == 28'd0) begin
            result = {big[31] & sml[31], 31'd0};
        end else if (uflow) begin
            result = {big[31], 31'd0};
        end else if (exp_n >= 10'd255) begin
            result = FP32_PINF | {big[31], 31'd0};
        end else begin
            result = {big[31], exp_n[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one two-stage fp32 adder pipeline among NUM_REQ requesters.
// Define FP_ADD_ARB_PERF_EN to build the perf_ops/perf_stall counters; otherwise they read 0.
module fp_add_arbiter
    import fp_nn_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  fp32_t [NUM_REQ-1:0] req_dataa,
    input  fp32_t [NUM_REQ-1:0] req_datab,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output fp32_t               rsp_result,
    output logic [PERF_W-1:0]   perf_ops,
    output logic [PERF_W-1:0]   perf_stall
);

    logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    fp32_t              s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_res_q, s2_res_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      cand;
    logic               found, s1_advance, s1_free, accept;
    fp32_t              add_res;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[ID_W-1:0]]   = 1'b1;
                grant_idx               = cand[ID_W-1:0];
            end
        end
    end

    assign s1_advance = s1_valid_q && (!s2_valid_q || rsp_ready);
    assign s1_free    = !s1_valid_q || s1_advance;
    // Gated by reset so req_ready drops asynchronously with the registers.
    assign req_ready  = reset ? '0 : (grant & {NUM_REQ{s1_free}});
    assign accept     = |req_ready;

    fp_adder u_adder (
        .dataa  (s1_a_q),
        .datab  (s1_b_q),
        .result (add_res)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_id_d    = s2_id_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_dataa[grant_idx];
            s1_b_d     = req_datab[grant_idx];
            s1_id_d    = grant_idx;
            rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
        if (s1_advance) begin
            s2_valid_d = 1'b1;
            s2_res_d   = add_res;
            s2_id_d    = s1_id_q;
        end else if (rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            rr_ptr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            rr_ptr_q   <= rr_ptr_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign rsp_valid  = s2_valid_q;
    assign rsp_id     = s2_id_q;
    assign rsp_result = s2_res_q;

`ifdef FP_ADD_ARB_PERF_EN
    logic [PERF_W-1:0] ops_q, ops_d, stall_q, stall_d;

    always_comb begin
        ops_d   = ops_q;
        stall_d = stall_q;
        if (accept && (ops_q != '1)) begin
            ops_d = ops_q + 1'b1;
        end
        if (s2_valid_q && !rsp_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            ops_q   <= ops_d;
            stall_q <= stall_d;
        end
    end

    assign perf_ops   = ops_q;
    assign perf_stall = stall_q;
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a queue-based pipeline model and real-arithmetic fp model.
module tb_fp_add_arbiter;
    import fp_nn_pkg::*;

    logic              clk;
    logic              reset;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][31:0]  req_dataa;
    logic [3:0][31:0]  req_datab;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_result;
    logic [31:0]       perf_ops;
    logic [31:0]       perf_stall;

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] va [12];
    logic [31:0] vb [12];

    typedef struct {
        int          id;
        logic [31:0] res;
    } ent_t;

    ent_t        fifo [$];
    bit          m_out   = 0;
    int          m_ptr   = 0;
    int unsigned m_ops   = 0;
    int unsigned m_stall = 0;

    fp_add_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_perf(input int unsigned v);
`ifdef FP_ADD_ARB_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // fp32 -> real, subnormals read as zero
    function automatic real to_r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // real -> fp32 with round-to-nearest-even
    function automatic logic [31:0] from_r(input real r);
        logic [63:0] d;
        logic [24:0] mant;
        logic [28:0] rem;
        int          e;
        d    = $realtobits(r);
        e    = int'(d[62:52]) - 896;
        mant = {2'b01, d[51:29]};
        rem  = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mant[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        bit  nan_a, nan_b, inf_a, inf_b;
        real r;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (nan_a || nan_b) return FP32_QNAN;
        if (inf_a && inf_b && (a[31] != b[31])) return FP32_QNAN;
        if (inf_a) return a;
        if (inf_b) return b;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
        r = to_r(a) + to_r(b);
        if (r == 0.0) return 32'd0;
        return from_r(r);
    endfunction

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Reference pipeline: in-flight ops in order; m_out marks the head as presented.
    initial begin
        int   mg;
        bit   macc;
        ent_t ent;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                fifo.delete();
                m_out   = 0;
                m_ptr   = 0;
                m_ops   = 0;
                m_stall = 0;
            end else begin
                mg   = pick(req_valid, m_ptr);
                macc = (mg >= 0) && (fifo.size() < 2 || rsp_ready);
                if (m_out && !rsp_ready) m_stall++;
                if (m_out && rsp_ready) begin
                    void'(fifo.pop_front());
                    m_out = 0;
                end
                if (!m_out && fifo.size() > 0) m_out = 1;
                if (macc) begin
                    ent.id  = mg;
                    ent.res = model_add(req_dataa[mg], req_datab[mg]);
                    fifo.push_back(ent);
                    m_ptr = (mg + 1) % 4;
                    m_ops++;
                end
            end
        end
    end

    initial begin
        int          g;
        logic [31:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (!reset) begin
                g       = pick(req_valid, m_ptr);
                exp_rdy = (g >= 0 && (fifo.size() < 2 || rsp_ready)) ? (32'd1 << g) : 32'd0;
                check("req_ready", 32'(req_ready), exp_rdy);
                check("rsp_valid", 32'(rsp_valid), 32'(m_out));
                if (m_out) begin
                    check("rsp_id", 32'(rsp_id), 32'(fifo[0].id));
                    check("rsp_result", rsp_result, fifo[0].res);
                end
                check("perf_ops", perf_ops, exp_perf(m_ops));
                check("perf_stall", perf_stall, exp_perf(m_stall));
            end
        end
    end

    task automatic set_data(input int base);
        for (int i = 0; i < 4; i++) begin
            req_dataa[i] = va[(base + i) % 12];
            req_datab[i] = vb[(base + i) % 12];
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'd0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic single_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expv);
        req_dataa[idx] = a;
        req_datab[idx] = b;
        req_valid      = 4'd0;
        req_valid[idx] = 1'b1;
        rsp_ready      = 1'b1;
        @(negedge clk);
        check("single ready", 32'(req_ready), 32'd1 << idx);
        @(posedge clk);
        #1 req_valid = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("single rsp_valid", 32'(rsp_valid), 32'd1);
        check("single rsp_id", 32'(rsp_id), 32'(idx));
        check("single rsp_result", rsp_result, expv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 4'd0;
        rsp_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        va[0]  = 32'h3F80_0000; vb[0]  = 32'h4000_0000;
        va[1]  = 32'h3FC0_0000; vb[1]  = 32'h4020_0000;
        va[2]  = 32'h4040_0000; vb[2]  = 32'hBF80_0000;
        va[3]  = 32'h3F00_0000; vb[3]  = 32'h3E80_0000;
        va[4]  = 32'hC0A0_0000; vb[4]  = 32'h4040_0000;
        va[5]  = 32'h4B80_0000; vb[5]  = 32'h4040_0000;
        va[6]  = 32'h7FC0_0000; vb[6]  = 32'h3F80_0000;
        va[7]  = 32'h3F80_0000; vb[7]  = 32'hBF80_0000;
        va[8]  = 32'h7F80_0000; vb[8]  = 32'h3F80_0000;
        va[9]  = 32'h7F80_0000; vb[9]  = 32'hFF80_0000;
        va[10] = 32'h8000_0000; vb[10] = 32'h8000_0000;
        va[11] = 32'h42C8_0000; vb[11] = 32'h3F80_0000;

        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        set_data(0);

        #12;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset perf_ops", perf_ops, 32'd0);
        check("reset perf_stall", perf_stall, 32'd0);

        check("model 1+2", model_add(va[0], vb[0]), 32'h4040_0000);
        check("model 1.5+2.5", model_add(va[1], vb[1]), 32'h4080_0000);
        check("model -5+3", model_add(va[4], vb[4]), 32'hC000_0000);
        check("model rne tie", model_add(va[5], vb[5]), 32'h4B80_0002);
        check("model nan", model_add(va[6], vb[6]), 32'h7FC0_0000);
        check("model inf-inf", model_add(va[9], vb[9]), 32'h7FC0_0000);
        check("model -0+-0", model_add(va[10], vb[10]), 32'h8000_0000);

        @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 4'd0;

        single_op(2, va[0], vb[0], 32'h4040_0000);
        single_op(0, va[6], vb[6], 32'h7FC0_0000);
        single_op(1, va[7], vb[7], 32'h0000_0000);
        single_op(3, va[11], vb[11], 32'h42CA_0000);
        single_op(2, va[3], vb[3], 32'h3F40_0000);

        // Fairness with all requesters continuously asserted
        do_reset();
        set_data(0);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fair grant", 32'(req_ready), 32'd1 << (k % 4));
            @(posedge clk);
            #1;
        end
        idle(3);
        check("fair perf_ops", perf_ops, exp_perf(8));
        check("fair perf_stall", perf_stall, 32'd0);

        // Backpressure: two accepts fill S1/S2, then five stalled cycles
        do_reset();
        set_data(4);
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("bp ready", 32'(req_ready), (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : 32'd0);
            if (k >= 2) begin
                check("bp rsp_valid", 32'(rsp_valid), 32'd1);
                check("bp rsp_result stable", rsp_result, 32'hC000_0000);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        req_valid = 4'd0;
        @(negedge clk);
        check("bp perf_stall", perf_stall, exp_perf(5));
        check("bp drain0 id", 32'(rsp_id), 32'd0);
        check("bp drain0 result", rsp_result, 32'hC000_0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp drain1 valid", 32'(rsp_valid), 32'd1);
        check("bp drain1 id", 32'(rsp_id), 32'd1);
        check("bp drain1 result", rsp_result, 32'h4B80_0002);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp empty", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back special values from one requester
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int v = 0; v < 12; v++) begin
            req_dataa[0] = va[v];
            req_datab[0] = vb[v];
            @(posedge clk);
            #1;
        end
        idle(3);

        // Mixed traffic: shifting request masks, dropped requests, periodic stalls
        for (int c = 0; c < 48; c++) begin
            req_valid = 4'((c * 7 + 5) % 16);
            rsp_ready = (c % 4) != 3;
            set_data(c);
            @(posedge clk);
            #1;
        end
        idle(4);

        // Reset with S1 and S2 both occupied
        set_data(2);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        req_valid = 4'd0;
        #2 reset = 1'b1;
        #1;
        check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset req_ready", 32'(req_ready), 32'd0);
        check("midreset rsp_result", rsp_result, 32'd0);
        check("midreset perf_stall", perf_stall, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post-reset grant", 32'(req_ready), 32'd2);
        check("post-reset no stale rsp", 32'(rsp_valid), 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
